// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared helpers for the slave-NI request path: ceiling-log2 sizing functions
// and the default geometry of an admission stage instance.
package axi4_duth_noc_ni_pkg;

  // Smallest r such that 2**r >= x (0 for x <= 1).
  function automatic int log2c(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r = r + 1;
    return r;
  endfunction

  // Like log2c but never returns 0, so a single-valued field still gets one bit.
  function automatic int log2c_1if1(input int x);
    return (x <= 1) ? 1 : log2c(x);
  endfunction

  localparam int DEF_TRANSACTION_IDS = 16;
  localparam int DEF_EXT_SLAVES      = 4;
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_INFO_W          = 16;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_STALL_W         = 8;

endpackage

// File: rtl/axi_req_admission_stage_fifo.sv
// Synchronous FIFO holding packed admission requests. Read data is the head
// entry (valid whenever empty=0); pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module admission_fifo
  import axi4_duth_noc_ni_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = log2c_1if1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage array: written at the tail on push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer advance; a reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/axi_req_admission_stage.sv
// Request admission stage: buffers AR/AW requests, offers the head to the
// reordering unit and registers a qualified head, tagged with its final
// destination Slave, toward the packetizer.
//
// Handshakes: every channel transfers on a clock edge where valid and ready
// are both high; a valid source keeps its payload stable until that edge.
// The reordering-unit channel is a one-shot request: ru_req_valid is only
// raised when the output register can accept, so ru_req_valid & qualifies is
// always exactly one admission (the unit counts it as an issued transaction).
module axi_req_admission_stage
  import axi4_duth_noc_ni_pkg::*;
#(
  parameter int TRANSACTION_IDS = DEF_TRANSACTION_IDS,
  parameter int EXT_SLAVES      = DEF_EXT_SLAVES,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int INFO_W          = DEF_INFO_W,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int STALL_W         = DEF_STALL_W,
  // Derived widths; leave at their defaults.
  parameter int TID_W           = log2c_1if1(TRANSACTION_IDS),
  parameter int DST_W           = log2c_1if1(EXT_SLAVES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TID_W-1:0]      in_tid,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [INFO_W-1:0]     in_info,
  input  logic [EXT_SLAVES-1:0] in_avail_dsts,
  output logic                  ru_req_valid,
  output logic [TID_W-1:0]      ru_req_tid,
  output logic [EXT_SLAVES-1:0] ru_req_avail_dsts,
  input  logic                  ru_req_qualifies,
  input  logic [DST_W-1:0]      ru_req_dst_final,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TID_W-1:0]      out_tid,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [INFO_W-1:0]     out_info,
  output logic [DST_W-1:0]      out_dst,
  output logic [STALL_W-1:0]    stall_cnt
);

  typedef struct packed {
    logic [TID_W-1:0]      tid;
    logic [ADDR_W-1:0]     addr;
    logic [INFO_W-1:0]     info;
    logic [EXT_SLAVES-1:0] avail_dsts;
  } adm_req_t;

  localparam int REQ_W = $bits(adm_req_t);

  adm_req_t wr_req;
  adm_req_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     slot_free;
  logic     fire;

  assign wr_req = '{tid: in_tid, addr: in_addr, info: in_info, avail_dsts: in_avail_dsts};

  // Upstream is held off during reset and whenever the buffer is full.
  assign in_ready  = !rst && !full;
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  // Only offer the head when the output register can take it this cycle.
  assign ru_req_valid      = !empty && slot_free;
  assign ru_req_tid        = head.tid;
  assign ru_req_avail_dsts = head.avail_dsts;
  assign fire              = ru_req_valid && ru_req_qualifies;

  admission_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_req),
    .pop   (fire),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Output register: loads on admission, clears after a handshake with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tid   <= '0;
      out_addr  <= '0;
      out_info  <= '0;
      out_dst   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_tid   <= head.tid;
      out_addr  <= head.addr;
      out_info  <= head.info;
      out_dst   <= ru_req_dst_final;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Head-of-line stall counter: counts refused offers, saturates, clears on admission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (fire) begin
      stall_cnt <= '0;
    end else if (ru_req_valid && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  a_avail_nonzero: assert property (@(posedge clk) disable iff (rst)
    push |-> (in_avail_dsts != '0));

  a_ru_needs_slot: assert property (@(posedge clk) disable iff (rst)
    ru_req_valid |-> slot_free);

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable({out_tid, out_addr, out_info, out_dst})));

endmodule
